// File: rtl/lcdc_pkg.sv
// Shared definitions for the lcd_ctrl_gen image controller: command codes,
// controller FSM states and the home-origin helper.
package lcdc_pkg;

    localparam logic [3:0] CMD_WRITE  = 4'd0;
    localparam logic [3:0] CMD_UP     = 4'd1;
    localparam logic [3:0] CMD_DOWN   = 4'd2;
    localparam logic [3:0] CMD_LEFT   = 4'd3;
    localparam logic [3:0] CMD_RIGHT  = 4'd4;
    localparam logic [3:0] CMD_MAX    = 4'd5;
    localparam logic [3:0] CMD_MIN    = 4'd6;
    localparam logic [3:0] CMD_AVG    = 4'd7;
    localparam logic [3:0] CMD_CCW    = 4'd8;
    localparam logic [3:0] CMD_CW     = 4'd9;
    localparam logic [3:0] CMD_MIRX   = 4'd10;
    localparam logic [3:0] CMD_MIRY   = 4'd11;
    localparam logic [3:0] CMD_HOME   = 4'd12;
    localparam logic [3:0] CMD_INVERT = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CMD,
        ST_EXEC,
        ST_OUT,
        ST_DONE
    } state_t;

    // Home origin along one axis: the window sits just above/left of centre.
    function automatic int home_coord(input int dim);
        return dim / 2 - 1;
    endfunction

endpackage

// File: rtl/lcdc_win_alu.sv
// Combinational 2x2 window operator. Pixel order: p0 top-left, p1 top-right,
// p2 bottom-left, p3 bottom-right. Define LCDC_AVG_ROUND_EN for rounded AVG.
module lcdc_win_alu
    import lcdc_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    cmd,
    input  logic [DW-1:0] p0,
    input  logic [DW-1:0] p1,
    input  logic [DW-1:0] p2,
    input  logic [DW-1:0] p3,
    output logic [DW-1:0] r0,
    output logic [DW-1:0] r1,
    output logic [DW-1:0] r2,
    output logic [DW-1:0] r3,
    output logic          we
);

    logic [DW-1:0] max01, max23, max_all;
    logic [DW-1:0] min01, min23, min_all;
    logic [DW+1:0] sum, avg_full;
    logic [DW-1:0] avg;

    assign max01   = (p0 > p1) ? p0 : p1;
    assign max23   = (p2 > p3) ? p2 : p3;
    assign max_all = (max01 > max23) ? max01 : max23;
    assign min01   = (p0 < p1) ? p0 : p1;
    assign min23   = (p2 < p3) ? p2 : p3;
    assign min_all = (min01 < min23) ? min01 : min23;

    // Two guard bits hold the four-pixel sum and the rounding offset.
    assign sum = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
`ifdef LCDC_AVG_ROUND_EN
    assign avg_full = sum + (DW+2)'(2);
`else
    assign avg_full = sum;
`endif
    assign avg = DW'(avg_full >> 2);

    always_comb begin
        r0 = p0;
        r1 = p1;
        r2 = p2;
        r3 = p3;
        we = 1'b1;
        case (cmd)
            CMD_MAX:    begin r0 = max_all; r1 = max_all; r2 = max_all; r3 = max_all; end
            CMD_MIN:    begin r0 = min_all; r1 = min_all; r2 = min_all; r3 = min_all; end
            CMD_AVG:    begin r0 = avg;     r1 = avg;     r2 = avg;     r3 = avg;     end
            CMD_CCW:    begin r0 = p1; r1 = p3; r2 = p0; r3 = p2; end
            CMD_CW:     begin r0 = p2; r1 = p0; r2 = p3; r3 = p1; end
            CMD_MIRX:   begin r0 = p2; r1 = p3; r2 = p0; r3 = p1; end
            CMD_MIRY:   begin r0 = p1; r1 = p0; r2 = p3; r3 = p2; end
            CMD_INVERT: begin r0 = ~p0; r1 = ~p1; r2 = ~p2; r3 = ~p3; end
            default:    we = 1'b0;
        endcase
    end

endmodule

// File: rtl/lcd_ctrl_gen.sv
// Parametrised image controller: loads an image from IROM, runs 2x2 window
// commands, streams the result to IRAM. Optional macro: LCDC_AVG_ROUND_EN.
module lcd_ctrl_gen
    import lcdc_pkg::*;
#(
    parameter  int DW    = 8,
    parameter  int IMG_W = 8,
    parameter  int IMG_H = 8,
    localparam int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    output logic          IRAM_valid,
    output logic [DW-1:0] IRAM_D,
    output logic [AW-1:0] IRAM_A,
    output logic          busy,
    output logic          done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [XW-1:0] HOME_X    = XW'(home_coord(IMG_W));
    localparam logic [YW-1:0] HOME_Y    = YW'(home_coord(IMG_H));
    localparam logic [XW-1:0] X_MAX     = XW'(IMG_W - 2);
    localparam logic [YW-1:0] Y_MAX     = YW'(IMG_H - 2);
    localparam logic [XW-1:0] X_ONE     = XW'(1);
    localparam logic [YW-1:0] Y_ONE     = YW'(1);

    state_t        state_reg;
    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic [3:0]    cmd_reg;
    logic          cap_vld_reg;
    logic [AW-1:0] cap_addr_reg;
    logic [DW-1:0] mem [0:N-1];

    logic [AW-1:0] a0, a1, a2, a3;
    logic [DW-1:0] r0, r1, r2, r3;
    logic          alu_we;
    logic          exec_we;

    // Power-of-two width makes raster address a plain {y, x} concatenation.
    assign a0 = {y_reg, x_reg};
    assign a1 = {y_reg, x_reg + X_ONE};
    assign a2 = {y_reg + Y_ONE, x_reg};
    assign a3 = {y_reg + Y_ONE, x_reg + X_ONE};

    lcdc_win_alu #(.DW(DW)) u_alu (
        .cmd (cmd_reg),
        .p0  (mem[a0]),
        .p1  (mem[a1]),
        .p2  (mem[a2]),
        .p3  (mem[a3]),
        .r0  (r0),
        .r1  (r1),
        .r2  (r2),
        .r3  (r3),
        .we  (alu_we)
    );

    assign exec_we = (state_reg == ST_EXEC) && alu_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (cap_vld_reg) begin
                mem[cap_addr_reg] <= IROM_Q;
            end
            // All four writes land together from pre-command values.
            if (exec_we) begin
                mem[a0] <= r0;
                mem[a1] <= r1;
                mem[a2] <= r2;
                mem[a3] <= r3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            x_reg        <= HOME_X;
            y_reg        <= HOME_Y;
            cmd_reg      <= '0;
            cap_vld_reg  <= 1'b0;
            cap_addr_reg <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            IROM_rd      <= 1'b0;
            IROM_A       <= '0;
            IRAM_valid   <= 1'b0;
            IRAM_A       <= '0;
            IRAM_D       <= '0;
        end else begin
            // ROM data returns one cycle after the address; remember where it goes.
            cap_vld_reg  <= IROM_rd;
            cap_addr_reg <= IROM_A;
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_LOAD;
                    IROM_rd   <= 1'b1;
                    IROM_A    <= '0;
                end
                ST_LOAD: begin
                    if (IROM_rd) begin
                        if (IROM_A == ADDR_LAST) begin
                            IROM_rd <= 1'b0;
                        end else begin
                            IROM_A <= IROM_A + ADDR_ONE;
                        end
                    end
                    if (cap_vld_reg && (cap_addr_reg == ADDR_LAST)) begin
                        state_reg <= ST_CMD;
                        busy      <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (cmd_valid) begin
                        busy    <= 1'b1;
                        cmd_reg <= cmd;
                        if (cmd == CMD_WRITE) begin
                            state_reg  <= ST_OUT;
                            IRAM_valid <= 1'b1;
                            IRAM_A     <= '0;
                            IRAM_D     <= mem[0];
                        end else begin
                            state_reg <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    case (cmd_reg)
                        CMD_UP:    if (y_reg != '0)    y_reg <= y_reg - Y_ONE;
                        CMD_DOWN:  if (y_reg != Y_MAX) y_reg <= y_reg + Y_ONE;
                        CMD_LEFT:  if (x_reg != '0)    x_reg <= x_reg - X_ONE;
                        CMD_RIGHT: if (x_reg != X_MAX) x_reg <= x_reg + X_ONE;
                        CMD_HOME: begin
                            x_reg <= HOME_X;
                            y_reg <= HOME_Y;
                        end
                        default: ;
                    endcase
                    state_reg <= ST_CMD;
                    busy      <= 1'b0;
                end
                ST_OUT: begin
                    if (IRAM_A == ADDR_LAST) begin
                        IRAM_valid <= 1'b0;
                        done       <= 1'b1;
                        state_reg  <= ST_DONE;
                    end else begin
                        IRAM_A <= IRAM_A + ADDR_ONE;
                        IRAM_D <= mem[IRAM_A + ADDR_ONE];
                    end
                end
                ST_DONE: ;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
